// File: rtl/dpram_be.sv
// ---------------------------------------------------------------------------
// dpram_be : simple dual-port RAM, one write port, one read port, one clock.
//   - Per-byte write enables.
//   - Pipelined read with 1 or 2 cycles of latency.
//   - Selectable same-address read-during-write result ("OLD" or "NEW").
//   - Optional zeroing sweep after reset; requests are dropped until it ends.
// ---------------------------------------------------------------------------
module dpram_be #(
    parameter int    ADDR_WIDTH    = 12,
    parameter int    DATA_WIDTH    = 64,
    parameter int    RD_LATENCY    = 1,
    parameter string RDW_MODE      = "OLD",
    parameter int    INIT_ON_RESET = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wmask,
    input  logic [ADDR_WIDTH-1:0]     waddr,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     raddr,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      rvalid,
    output logic                      ready
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam bit NEW_MODE = (RDW_MODE == "NEW");
    localparam bit DO_SWEEP = (INIT_ON_RESET != 0);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RST_STATE = DO_SWEEP ? ST_INIT : ST_RUN;

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   mask
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (mask[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                result[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return result;
    endfunction

    // Control state
    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   cnt_d;
    logic                    ready_q;
    logic                    ready_d;

    // Storage (no reset: only the sweep clears it)
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Internal write port after sweep/user arbitration
    logic                    we_s;
    logic [ADDR_WIDTH-1:0]   wa_s;
    logic [DATA_WIDTH-1:0]   wd_s;
    logic [BE_WIDTH-1:0]     wm_s;

    // Read path
    logic                    rd_acc_s;
    logic                    wr_acc_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [DATA_WIDTH-1:0]   rd_merged_s;
    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;

    assign rd_acc_s = ready_q & rd_en;
    assign wr_acc_s = ready_q & wr_en;

    // State, sweep counter and ready flag registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= {ADDR_WIDTH{1'b0}};
            ready_q <= ~DO_SWEEP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: INIT walks every address once, then RUN until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
        ready_d = (state_d == ST_RUN);
    end

    // Write-port arbitration: the sweep owns the port during INIT.
    always_comb begin
        we_s = 1'b0;
        wa_s = waddr;
        wd_s = wdata;
        wm_s = wmask;
        if (state_q == ST_INIT) begin
            we_s = 1'b1;
            wa_s = cnt_q;
            wd_s = {DATA_WIDTH{1'b0}};
            wm_s = {BE_WIDTH{1'b1}};
        end else begin
            we_s = wr_acc_s;
        end
    end

    // Byte-enabled array write.
    always_ff @(posedge sys_clk) begin
        if (we_s) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (wm_s[b]) begin
                    mem_q[wa_s][8*b +: 8] <= wd_s[8*b +: 8];
                end
            end
        end
    end

    assign rd_word_s = mem_q[raddr];

    // Same-address bypass: in NEW mode the response reflects this cycle's write.
    always_comb begin
        rd_merged_s = rd_word_s;
        if (NEW_MODE && wr_acc_s && (waddr == raddr)) begin
            rd_merged_s = byte_merge(rd_word_s, wdata, wmask);
        end else begin
            rd_merged_s = rd_word_s;
        end
    end

    // First read stage; data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_valid_q <= rd_acc_s;
            if (rd_acc_s) begin
                s1_data_q <= rd_merged_s;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_valid_q;
        logic [DATA_WIDTH-1:0] s2_data_q;

        // Second read stage for the two-cycle configuration.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= {DATA_WIDTH{1'b0}};
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rvalid = s2_valid_q;
        assign rdata  = s2_data_q;
    end else begin : g_lat1
        assign rvalid = s1_valid_q;
        assign rdata  = s1_data_q;
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_dpram_be.sv
// ---------------------------------------------------------------------------
// tb_dpram_be : two instances share one stimulus stream.
//   u_dut_a : RD_LATENCY=1, RDW_MODE="OLD"
//   u_dut_b : RD_LATENCY=2, RDW_MODE="NEW"
// A word-array model with per-instance response queues predicts every cycle.
// ---------------------------------------------------------------------------
module tb_dpram_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 16;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wmask;
    logic [AW-1:0] waddr;
    logic          wr_en;
    logic [AW-1:0] raddr;
    logic          rd_en;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b;
    logic          ready_a, ready_b;

    always #5 sys_clk = ~sys_clk;

    dpram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1),
               .RDW_MODE("OLD"), .INIT_ON_RESET(1)) u_dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .wdata(wdata), .wmask(wmask), .waddr(waddr), .wr_en(wr_en),
        .raddr(raddr), .rd_en(rd_en),
        .rdata(rdata_a), .rvalid(rvalid_a), .ready(ready_a)
    );

    dpram_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2),
               .RDW_MODE("NEW"), .INIT_ON_RESET(1)) u_dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .wdata(wdata), .wmask(wmask), .waddr(waddr), .wr_en(wr_en),
        .raddr(raddr), .rd_en(rd_en),
        .rdata(rdata_b), .rvalid(rvalid_b), .ready(ready_b)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [DW-1:0] mem_m [DEPTH];
    int            checks      = 0;
    int            failures    = 0;
    int            cyc         = 0;
    int            sweep_cnt   = 0;
    bit            model_ready = 1'b0;
    logic [DW-1:0] last_a      = '0;
    logic [DW-1:0] last_b      = '0;
    logic [DW-1:0] seen_a      = '0;
    logic [DW-1:0] seen_b      = '0;
    int            pulses_a    = 0;
    int            pulses_b    = 0;

    // Count one comparison and report it if it does not match.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Masked write as arithmetic: expand the byte mask to a bit mask and blend.
    function automatic logic [DW-1:0] blend(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] m);
        logic [DW-1:0] bm;
        bm = '0;
        for (int b = 0; b < BW; b++) begin
            if (m[b]) bm = bm | (32'hFF << (8 * b));
        end
        return (o & ~bm) | (n & bm);
    endfunction

    task automatic port_check(input string tag, input bit has, input logic [DW-1:0] ed,
                              input logic v, input logic [DW-1:0] d,
                              inout logic [DW-1:0] last);
        if (has) begin
            check_eq({tag, ".rvalid"}, 64'(v), 64'(1'b1));
            check_eq({tag, ".rdata"}, 64'(d), 64'(ed));
            last = ed;
        end else begin
            check_eq({tag, ".rvalid_idle"}, 64'(v), 64'(1'b0));
            check_eq({tag, ".rdata_hold"}, 64'(d), 64'(last));
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wdata = '0; wmask = '0; waddr = '0; raddr = '0;
    endtask

    // One clock: advance the model at the edge, then compare both instances.
    task automatic step();
        logic [DW-1:0] oldw;
        logic [DW-1:0] neww;
        logic [DW-1:0] ed;
        bit            has;
        @(posedge sys_clk);
        cyc++;
        if (model_ready && rd_en) begin
            oldw = mem_m[raddr];
            neww = (wr_en && waddr == raddr) ? blend(oldw, wdata, wmask) : oldw;
            q_a.push_back('{due: cyc,     data: oldw});
            q_b.push_back('{due: cyc + 1, data: neww});
        end
        if (model_ready && wr_en) mem_m[waddr] = blend(mem_m[waddr], wdata, wmask);
        if (!model_ready) begin
            sweep_cnt++;
            if (sweep_cnt >= DEPTH) model_ready = 1'b1;
        end
        #1;
        check_eq("ready_a", 64'(ready_a), 64'(model_ready));
        check_eq("ready_b", 64'(ready_b), 64'(model_ready));

        has = (q_a.size() > 0) && (q_a[0].due == cyc);
        ed  = '0;
        if (has) begin ed = q_a[0].data; q_a.delete(0); end
        port_check("a", has, ed, rvalid_a, rdata_a, last_a);
        if (rvalid_a === 1'b1) begin seen_a = rdata_a; pulses_a++; end

        has = (q_b.size() > 0) && (q_b[0].due == cyc);
        ed  = '0;
        if (has) begin ed = q_b[0].data; q_b.delete(0); end
        port_check("b", has, ed, rvalid_b, rdata_b, last_b);
        if (rvalid_b === 1'b1) begin seen_b = rdata_b; pulses_b++; end
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        idle();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        check_eq("rst.ready_a",  64'(ready_a),  64'(1'b0));
        check_eq("rst.ready_b",  64'(ready_b),  64'(1'b0));
        check_eq("rst.rvalid_a", 64'(rvalid_a), 64'(1'b0));
        check_eq("rst.rvalid_b", 64'(rvalid_b), 64'(1'b0));
        check_eq("rst.rdata_a",  64'(rdata_a),  64'(0));
        check_eq("rst.rdata_b",  64'(rdata_b),  64'(0));
        q_a.delete();
        q_b.delete();
        last_a      = '0;
        last_b      = '0;
        sweep_cnt   = 0;
        model_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] m);
        idle(); wr_en = 1'b1; waddr = a; wdata = d; wmask = m;
        step();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        idle(); rd_en = 1'b1; raddr = a;
        step();
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic poke_during_init();
        wr_en = 1'b1; waddr = 4'd2; wdata = 32'hDEADBEEF; wmask = 4'hF;
        rd_en = 1'b1; raddr = 4'd2;
    endtask

    initial begin
        idle();
        apply_reset();

        // Requests during the sweep, then abort the sweep at cycle 7.
        for (int i = 0; i < 7; i++) begin poke_during_init(); step(); end
        apply_reset();

        // Full sweep again with requests still pending; ready must stay low 16 cycles.
        for (int i = 0; i < DEPTH; i++) begin poke_during_init(); step(); end
        idle();

        // Every word reads back zero, one pulse per read.
        pulses_a = 0; pulses_b = 0;
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        drain(3);
        check_eq("init.pulses_a", 64'(pulses_a), 64'(16));
        check_eq("init.pulses_b", 64'(pulses_b), 64'(16));
        check_eq("init.addr2_a", 64'(mem_m[2]), 64'(0));

        // Byte-mask merge.
        wr(4'd3, 32'hAABBCCDD, 4'hF);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3);
        drain(3);
        check_eq("mask.seen_a", 64'(seen_a), 64'(32'hAA22CC44));
        check_eq("mask.seen_b", 64'(seen_b), 64'(32'hAA22CC44));

        // Read during write on the same address, then read the next cycle.
        wr(4'd5, 32'h01020304, 4'hF);
        idle();
        wr_en = 1'b1; waddr = 4'd5; wdata = 32'hFFFFFFFF; wmask = 4'b0011;
        rd_en = 1'b1; raddr = 4'd5;
        step();
        check_eq("rdw.old_a", 64'(seen_a), 64'(32'h01020304));
        rd(4'd5);
        check_eq("rdw.new_b", 64'(seen_b), 64'(32'h0102FFFF));
        idle();
        step();
        check_eq("raw.next_a", 64'(seen_a), 64'(32'h0102FFFF));
        step();
        check_eq("raw.next_b", 64'(seen_b), 64'(32'h0102FFFF));
        drain(2);

        // Streaming: eight back-to-back reads.
        for (int i = 0; i < 8; i++) wr(AW'(i), 32'h10000000 + 32'(i) * 32'h01010101, 4'hF);
        pulses_a = 0; pulses_b = 0;
        for (int i = 0; i < 8; i++) rd(AW'(i));
        drain(3);
        check_eq("stream.pulses_a", 64'(pulses_a), 64'(8));
        check_eq("stream.pulses_b", 64'(pulses_b), 64'(8));
        check_eq("stream.last_b", 64'(seen_b), 64'(32'h17070707));

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            wr_en = 1'($urandom_range(0, 1));
            rd_en = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, DEPTH - 1));
            raddr = ($urandom_range(0, 1) == 1) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            wdata = $urandom;
            wmask = BW'($urandom_range(0, 15));
            step();
        end
        drain(4);
        check_eq("end.q_a_empty", 64'(q_a.size()), 64'(0));
        check_eq("end.q_b_empty", 64'(q_b.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
